// File: rtl/ucode_pkg.sv
// Shared types and field encodings for the microprogram sequencer.
package ucode_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int OPS_W_DEF  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [1:0] COND_ALWAYS    = 2'b00;
    localparam logic [1:0] COND_ZERO      = 2'b01;
    localparam logic [1:0] COND_CORE_DONE = 2'b10;
    localparam logic [1:0] COND_HALT      = 2'b11;

endpackage

// File: rtl/micro_sequencer_branch_eval.sv
// Decodes the ROM condition/BT fields into a branch-taken or halt decision.
module branch_eval
    import ucode_pkg::*;
(
    input  logic [1:0] condition,
    input  logic       bt,
    input  logic       zero_flag,
    input  logic       core_done,
    output logic       taken,
    output logic       halt
);

    logic cond_true;

    always_comb begin
        cond_true = 1'b1;
        halt      = 1'b0;
        unique case (condition)
            COND_ALWAYS:    cond_true = 1'b1;
            COND_ZERO:      cond_true = zero_flag;
            COND_CORE_DONE: cond_true = core_done;
            COND_HALT:      halt      = 1'b1;
        endcase
    end

    // bt selects polarity: jump when the condition matches it
    assign taken = (cond_true == bt);

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: walks the external microcode ROM and issues its control words.
module micro_sequencer
    import ucode_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                OPS_W      = OPS_W_DEF,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                WDOG_MAX   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    input  logic              zero_flag,
    input  logic              core_done,
    input  logic [1:0]        condition,
    input  logic              bt,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [OPS_W-1:0]  ops,
    output logic [ADDR_W-1:0] upc,
    output logic [OPS_W-1:0]  ops_out,
    output logic              ops_valid,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int               CNT_W    = $clog2(WDOG_MAX + 1);
    localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(WDOG_MAX);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [OPS_W-1:0]  ops_q, ops_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              taken;
    logic              halt;

    branch_eval u_branch_eval (
        .condition (condition),
        .bt        (bt),
        .zero_flag (zero_flag),
        .core_done (core_done),
        .taken     (taken),
        .halt      (halt)
    );

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        ops_d   = ops_q;
        vld_d   = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = RUN;
                    upc_d   = START_ADDR;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                // abort, then watchdog, then stall, then halt/issue
                if (abort) begin
                    state_d = IDLE;
                    ops_d   = '0;
                end else if (cnt_q == WDOG_LIM) begin
                    state_d = IDLE;
                    ops_d   = '0;
                    err_d   = 1'b1;
                end else if (!stall) begin
                    if (halt) begin
                        state_d = DONE;
                        ops_d   = '0;
                    end else begin
                        ops_d = ops;
                        vld_d = 1'b1;
                        upc_d = taken ? jump_addr : upc_q + 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                ops_d   = '0;
            end
            default: begin
                state_d = IDLE;
                ops_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            upc_q   <= START_ADDR;
            ops_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            ops_q   <= ops_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign upc       = upc_q;
    assign ops_out   = ops_q;
    assign ops_valid = vld_q;
    assign error     = err_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer for the control unit: owns the micro-PC, drives it into the combinational microcode ROM, and decodes the returned condition, BT and jump_addr fields to select the next micro-address.
- Registers the ROM's OPs word into a one-cycle-delayed control vector that the matrix-multiply datapath consumes.
- Provides a start/done handshake to the top level, a datapath stall input, abort, and a runaway watchdog.

Parameters:
- ADDR_W, 16, micro-address width; matches the microcode reg_out/jump_addr width.
- OPS_W, 6, control-word width; matches the microcode OPs width.
- START_ADDR, 0, micro-address loaded on start.
- WDOG_MAX, 4096, maximum issued micro-ops per run before error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  terminate the current run.
- stall  in  1  datapath not ready; freeze the sequencer.
- zero_flag  in  1  datapath zero/loop-count-expired status.
- core_done  in  1  all cores finished their tiles.
- condition  in  2  condition select from the ROM.
- bt  in  1  branch polarity from the ROM.
- jump_addr  in  ADDR_W  branch target from the ROM.
- ops  in  OPS_W  control word from the ROM.
- upc  out  ADDR_W  current micro-address; drives the ROM reg_out input.
- ops_out  out  OPS_W  registered control word to the datapath.
- ops_valid  out  1  ops_out is meaningful this cycle.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at normal completion.
- error  out  1  sticky watchdog flag; cleared by start or rst.

Behaviour:
- Reset: a synchronous, active-high rst on clk sets state=IDLE, upc=START_ADDR, ops_out=0, ops_valid=0, busy=0, done=0, error=0, step counter=0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN when start=1. On that edge: upc<=START_ADDR, step counter<=0, error<=0.
- Condition evaluation (combinational, using the current ROM outputs):
  - condition 00: cond_true=1.
  - condition 01: cond_true=zero_flag.
  - condition 10: cond_true=core_done.
  - condition 11: HALT.
- Branch decision: taken = (cond_true == bt). So 00 with bt=1 is an unconditional jump, and 00 with bt=0 falls through.
- RUN step, when stall=0 and condition!=11:
  - ops_out<=ops, ops_valid<=1.
  - upc<=taken ? jump_addr : upc+1. Increment is modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000.
  - step counter increments.
- RUN with stall=1: upc, ops_out and step counter hold; ops_valid<=0. Stall takes priority over branch evaluation. Flags are re-sampled when stall drops.
- RUN with condition=11 (HALT), not stalled:
  - The HALT word's ops is not issued; ops_out<=0, ops_valid<=0.
  - State->DONE.
- DONE: done=1 for exactly one cycle, then IDLE. upc holds the HALT address.
- Latency: the ROM word at upc=N appears on ops_out on the clock edge after N is presented, i.e. one cycle.
- Throughput: one micro-op per unstalled cycle.
- Watchdog: if the step counter reaches WDOG_MAX in RUN, then error<=1, state->IDLE, ops_out<=0, ops_valid<=0, and no done pulse.
- Abort in RUN or DONE: state->IDLE next edge, ops_out<=0, ops_valid<=0, no done pulse. Abort has priority over stall, HALT and watchdog.
- start while busy: ignored.
- start and abort together in IDLE: abort wins; stay IDLE.
- rst mid-run: return to reset values on the next edge regardless of other inputs.
- busy is registered (state==RUN). It is not asserted during DONE.

Decomposition:
- Shared package ucode_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - condition codes COND_ALWAYS=2'b00, COND_ZERO=2'b01, COND_CORE_DONE=2'b10, COND_HALT=2'b11;
  - ADDR_W and OPS_W defaults.
- One natural sub-module, branch_eval (combinational): condition, bt, zero_flag, core_done -> taken, halt.
- The microcode ROM stays external and is connected through upc and the ROM field ports.

Test Plan:
- Linear run: ROM words 0..3 carry ops 1,2,3,4 with cond 00/bt 0; word 4 is HALT. Pulse start -> ops_out 1,2,3,4 on consecutive cycles, done pulses on the cycle after HALT, busy is low afterwards.
- Conditional loop: word 2 = cond 01/bt 0/jump 0; zero_flag low for two passes, then high -> upc sequence 0,1,2,0,1,2,0,1,2,3; ops_valid is continuous.
- Stall: assert stall for 3 cycles at upc=1 -> upc stays 1, ops_valid=0 for 3 cycles, ops_out is unchanged, and the sequence resumes with word 1's successor.
- Abort: assert abort at upc=2 with start=1 held -> IDLE next edge, ops_out=0, no done pulse, no restart while abort=1.
- Watchdog: WDOG_MAX=8, word 0 = cond 00/bt 1/jump 0 (self-loop) -> error=1 after 8 issued ops, state IDLE, no done. The next start clears error.
- Wrap and reset: START_ADDR=16'hFFFF with a fall-through word -> next upc=16'h0000. Asserting rst mid-run -> all outputs at reset values on the next edge.
